regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DW, 32, data width of the register-file write port.
REQ-002 Parameter: AW, 5, address width of the register-file write port (32 registers).
REQ-003 Port: clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Ports: reqN_valid  input  1,  reqN_addr  input  AW,  reqN_data  input  DW,  reqN_ready  output  1, for N = 0, 1, 2.
- Requester 0 is the pipeline writeback.
- Requester 1 is the multi-cycle unit.
- Requester 2 is the debug/loader port.
REQ-006 Ports: clr_start input 1 (clear request pulse), clr_busy output 1, clr_done output 1.
REQ-007 Ports: rf_we output 1, rf_waddr output AW, rf_wdata output DW; together they drive the single register-file write port.

Function
REQ-008 The block SHALL be a two-state FSM (IDLE, CLEAR) that shares one register-file write port among three requesters.
REQ-009 Handshake: a transfer on port N occurs in a cycle where reqN_valid=1 and reqN_ready=1.
- A requester holds valid, addr and data stable until the transfer completes.
REQ-010 In IDLE, at most one reqN_ready SHALL be high per cycle.
- reqN_ready is combinational from the valid inputs and the round-robin pointer.
- reqN_ready is never asserted while reqN_valid=0.
REQ-011 Round-robin arbitration: search order starts at pointer P (0..2) and wraps (P, P+1, P+2 mod 3); the first valid requester in that order is granted.
REQ-012 After a grant to requester N, P SHALL become (N+1) mod 3; P is unchanged in cycles without a grant.
REQ-013 Latency: a transfer in cycle t SHALL produce rf_we=1, rf_waddr=addr, rf_wdata=data in cycle t+1 (registered outputs, one write per cycle).
REQ-014 Transfers with addr=0 SHALL be accepted (ready high) but SHALL produce rf_we=0; rf_waddr and rf_wdata are don't-care in that case.
REQ-015 In IDLE, when clr_start=1 the FSM SHALL enter CLEAR.
- clr_start takes precedence over any pending grant in the same cycle; all readies are low in that cycle.
- A clear counter C is loaded with 1.
REQ-016 In CLEAR, each cycle SHALL register rf_we=1, rf_waddr=C, rf_wdata=0, then increment C.
- After the write with C=31 the FSM returns to IDLE.
- Total: 31 writes on 31 consecutive cycles.
REQ-017 clr_busy SHALL be high in every cycle the FSM is in CLEAR. All reqN_ready SHALL be low while clr_busy=1.
REQ-018 clr_done SHALL be a one-cycle pulse in the cycle rf_we is presented for address 31.
REQ-019 clr_start while in CLEAR SHALL be ignored; the sequence is not restarted.
REQ-020 In the first IDLE cycle after CLEAR, arbitration SHALL resume with the P value held before the clear.
REQ-021 Requests pending during CLEAR SHALL remain pending and SHALL be arbitrated normally after CLEAR.

Reset
REQ-022 On rst=1, asynchronously and regardless of clk:
- FSM returns to IDLE and P=0.
- C=1.
- rf_we=0, rf_waddr=0, rf_wdata=0.
- clr_busy=0, clr_done=0.
REQ-023 Reset asserted mid-CLEAR SHALL abort the sequence with no further writes; clr_done is not pulsed.
REQ-024 While rst=1, all reqN_ready SHALL be 0.

Configuration
REQ-025 Macro REGFILE_ARB_DEBUG_PORT_EN:
- When defined, requester 2 participates in arbitration as specified above.
- When undefined, req2_ready SHALL be tied 0 and req2_* inputs ignored; arbitration is round-robin over requesters 0 and 1 only (P in 0..1, next P = (N+1) mod 2).
- All other behaviour is identical in both builds.

Verification
REQ-026 After reset, req0, req1 and req2 all valid with addrs 3, 4, 5 and data 0xA, 0xB, 0xC, held:
- grants occur in order 0, 1, 2 on consecutive cycles;
- rf_we=1 with (3,0xA), (4,0xB), (5,0xC) on the following three cycles.
REQ-027 req1 only, addr 0, data 0xFFFF_FFFF -> req1_ready=1 and rf_we=0 on the next cycle.
REQ-028 clr_start pulse in IDLE with req0 valid (addr 7):
- clr_busy high for 31 cycles;
- rf_waddr sequence 1..31 with rf_wdata=0;
- clr_done high exactly with address 31;
- req0 granted only in the first IDLE cycle after CLEAR.
REQ-029 rst asserted after the 10th clear write -> rf_we=0 immediately; clr_busy=0; no clr_done; P=0 afterward.
REQ-030 Build without REGFILE_ARB_DEBUG_PORT_EN, all three valid:
- req2_ready stays 0;
- grants alternate 0, 1, 0, 1.
REQ-031 clr_start re-pulsed during CLEAR -> exactly 31 writes total and a single clr_done.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus: three requester channels, the clear
// control pair and the shared register-file write port.
// master = requesters/controller side, slave = arbiter side.
interface regfile_write_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // Requester 0: pipeline writeback
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  // Requester 1: multi-cycle unit
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  // Requester 2: debug/loader port
  logic          req2_valid;
  logic [AW-1:0] req2_addr;
  logic [DW-1:0] req2_data;
  logic          req2_ready;
  // Register-file clear control
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  // Shared register-file write port
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output req2_valid, req2_addr, req2_data,
    output clr_start,
    input  req0_ready, req1_ready, req2_ready,
    input  clr_busy, clr_done,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  req2_valid, req2_addr, req2_data,
    input  clr_start,
    output req0_ready, req1_ready, req2_ready,
    output clr_busy, clr_done,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// Shares one register-file write port between the pipeline writeback (0),
// the multi-cycle unit (1) and the debug/loader port (2) with round-robin
// arbitration, and runs a hardware clear sequence writing zero to
// registers 1..2**AW-1 on consecutive cycles.
// Build option: define REGFILE_ARB_DEBUG_PORT_EN to let requester 2
// take part in arbitration; otherwise its ready is tied low and only
// requesters 0 and 1 are arbitrated.
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

`ifdef REGFILE_ARB_DEBUG_PORT_EN
  localparam int NREQ = 3;
`else
  localparam int NREQ = 2;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  logic [2:0]    vld;
  logic [2:0]    gnt;
  logic [1:0]    gidx;
  logic [1:0]    srch;
  logic          found;
  logic          arb_en;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gdata;

  logic          rf_we_p1;
  logic [AW-1:0] rf_waddr_p1;
  logic [DW-1:0] rf_wdata_p1;
  logic          clr_done_p1;

  // Next requester index in round-robin order, wrapping at NREQ.
  function automatic logic [1:0] wrap_inc(input logic [1:0] n);
    if (n >= 2'(NREQ - 1)) return 2'd0;
    else                   return n + 2'd1;
  endfunction

  assign vld[0] = bus.req0_valid;
  assign vld[1] = bus.req1_valid;
`ifdef REGFILE_ARB_DEBUG_PORT_EN
  assign vld[2] = bus.req2_valid;
`else
  assign vld[2] = 1'b0;
  logic unused_req2;
  assign unused_req2 = ^{bus.req2_valid, bus.req2_addr, bus.req2_data, gnt[2]};
`endif

  // Grants only in IDLE; a clear request or reset blocks every grant.
  assign arb_en   = (state_q == IDLE) && !bus.clr_start && !rst;
  assign cnt_last = (cnt_q == {AW{1'b1}});

  // Round-robin search from the pointer; first valid requester wins.
  always_comb begin
    gnt   = 3'b000;
    gidx  = ptr_q;
    found = 1'b0;
    srch  = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_en && !found && vld[srch]) begin
        gnt[srch] = 1'b1;
        gidx      = srch;
        found     = 1'b1;
      end
      srch = wrap_inc(srch);
    end
  end

  // Select address/data of the granted requester.
  always_comb begin
    gaddr = bus.req0_addr;
    gdata = bus.req0_data;
    case (gidx)
      2'd1: begin
        gaddr = bus.req1_addr;
        gdata = bus.req1_data;
      end
`ifdef REGFILE_ARB_DEBUG_PORT_EN
      2'd2: begin
        gaddr = bus.req2_addr;
        gdata = bus.req2_data;
      end
`endif
      default: ;
    endcase
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
`ifdef REGFILE_ARB_DEBUG_PORT_EN
  assign bus.req2_ready = gnt[2];
`else
  assign bus.req2_ready = 1'b0;
`endif
  assign bus.clr_busy   = (state_q == CLEAR);

  // Next-state logic: clear entry/exit, clear counter and pointer update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end else if (found) begin
          ptr_d = wrap_inc(gidx);
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register; the pointer is held across a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- stage p1: registered register-file write port ----
  // Writes to register 0 are accepted but suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_p1    <= 1'b0;
      rf_waddr_p1 <= '0;
      rf_wdata_p1 <= '0;
      clr_done_p1 <= 1'b0;
    end else begin
      rf_we_p1    <= 1'b0;
      clr_done_p1 <= 1'b0;
      if (state_q == CLEAR) begin
        rf_we_p1    <= 1'b1;
        rf_waddr_p1 <= cnt_q;
        rf_wdata_p1 <= '0;
        clr_done_p1 <= cnt_last;
      end else if (found) begin
        rf_we_p1    <= |gaddr;
        rf_waddr_p1 <= gaddr;
        rf_wdata_p1 <= gdata;
      end
    end
  end

  assign bus.rf_we    = rf_we_p1;
  assign bus.rf_waddr = rf_waddr_p1;
  assign bus.rf_wdata = rf_wdata_p1;
  assign bus.clr_done = clr_done_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, round-robin order,
// address-0 suppression, clear sequence, clear restart and reset mid-clear.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   clr_writes;
  int   done_cnt;

  regfile_write_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  regfile_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rdy();
    return {bus.req2_ready, bus.req1_ready, bus.req0_ready};
  endfunction

  initial begin
    int exp_g [4];
    logic [2:0] one_hot;
    n_assert = 0;
    n_fail   = 0;
`ifdef REGFILE_ARB_DEBUG_PORT_EN
    exp_g = '{2, 0, 1, 2};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.req2_valid = 0; bus.req2_addr = '0; bus.req2_data = '0;
    bus.clr_start  = 0;

    // Reset state, readies held low under reset
    #2;
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    chk("rst_ready", 32'(rdy()), 32'h0);
    chk("rst_we", 32'(bus.rf_we), 32'h0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("rst_wdata", bus.rf_wdata, 32'h0);
    chk("rst_busy", 32'(bus.clr_busy), 32'h0);
    chk("rst_done", 32'(bus.clr_done), 32'h0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
    rst = 1'b0;

    // Three requesters, each drops valid after its transfer
    bus.req0_valid = 1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA;
    bus.req1_valid = 1; bus.req1_addr = 5'd4; bus.req1_data = 32'hB;
    bus.req2_valid = 1; bus.req2_addr = 5'd5; bus.req2_data = 32'hC;
    #1;
    chk("rr_c0_ready", 32'(rdy()), 32'h1);
    chk("rr_c0_we", 32'(bus.rf_we), 32'h0);
    tick();
    bus.req0_valid = 0;
    #1;
    chk("rr_c1_we", 32'(bus.rf_we), 32'h1);
    chk("rr_c1_waddr", 32'(bus.rf_waddr), 32'd3);
    chk("rr_c1_wdata", bus.rf_wdata, 32'hA);
    chk("rr_c1_ready", 32'(rdy()), 32'h2);
    tick();
    bus.req1_valid = 0;
    #1;
    chk("rr_c2_we", 32'(bus.rf_we), 32'h1);
    chk("rr_c2_waddr", 32'(bus.rf_waddr), 32'd4);
    chk("rr_c2_wdata", bus.rf_wdata, 32'hB);
`ifdef REGFILE_ARB_DEBUG_PORT_EN
    chk("rr_c2_ready", 32'(rdy()), 32'h4);
    tick();
    bus.req2_valid = 0;
    #1;
    chk("rr_c3_we", 32'(bus.rf_we), 32'h1);
    chk("rr_c3_waddr", 32'(bus.rf_waddr), 32'd5);
    chk("rr_c3_wdata", bus.rf_wdata, 32'hC);
`else
    chk("rr_c2_ready_no_dbg", 32'(rdy()), 32'h0);
    tick();
    bus.req2_valid = 0;
    #1;
    chk("rr_c3_we_no_dbg", 32'(bus.rf_we), 32'h0);
`endif
    tick();
    #1;
    chk("rr_c4_we", 32'(bus.rf_we), 32'h0);

    // Address 0 accepted but write suppressed
    bus.req1_valid = 1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFFFF_FFFF;
    #1;
    chk("a0_ready", 32'(rdy()), 32'h2);
    tick();
    bus.req1_valid = 0;
    #1;
    chk("a0_we", 32'(bus.rf_we), 32'h0);

    // All three held valid: grant order from the current pointer
    bus.req0_valid = 1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA;
    bus.req1_valid = 1; bus.req1_addr = 5'd4; bus.req1_data = 32'hB;
    bus.req2_valid = 1; bus.req2_addr = 5'd5; bus.req2_data = 32'hC;
    for (int i = 0; i < 4; i++) begin
      #1;
      one_hot = 3'b001 << exp_g[i];
      chk("alt_ready", 32'(rdy()), 32'(one_hot));
      if (i > 0) begin
        chk("alt_we", 32'(bus.rf_we), 32'h1);
        chk("alt_waddr", 32'(bus.rf_waddr), 32'(3 + exp_g[i-1]));
      end
      tick();
    end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req2_valid = 0;
    #1;
    chk("alt_last_waddr", 32'(bus.rf_waddr), 32'(3 + exp_g[3]));
    chk("alt_last_wdata", bus.rf_wdata, 32'(32'hA + exp_g[3]));
    tick();

    // Clear with a pending request; clr_start re-pulsed mid-clear
    bus.req0_valid = 1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77;
    bus.clr_start  = 1;
    #1;
    chk("clr_start_ready", 32'(rdy()), 32'h0);
    chk("clr_start_busy", 32'(bus.clr_busy), 32'h0);
    tick();
    bus.clr_start = 0;
    clr_writes = 0;
    done_cnt   = 0;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      #1;
      chk("clr_busy", 32'(bus.clr_busy), 32'h1);
      chk("clr_ready", 32'(rdy()), 32'h0);
      if (cyc >= 2) begin
        chk("clr_we", 32'(bus.rf_we), 32'h1);
        chk("clr_waddr", 32'(bus.rf_waddr), 32'(cyc - 1));
        chk("clr_wdata", bus.rf_wdata, 32'h0);
        chk("clr_done_early", 32'(bus.clr_done), 32'h0);
      end else begin
        chk("clr_first_we", 32'(bus.rf_we), 32'h0);
      end
      if (bus.rf_we === 1'b1) clr_writes++;
      if (bus.clr_done === 1'b1) done_cnt++;
      bus.clr_start = (cyc == 5);
      tick();
    end
    #1;
    chk("clr_end_busy", 32'(bus.clr_busy), 32'h0);
    chk("clr_end_we", 32'(bus.rf_we), 32'h1);
    chk("clr_end_waddr", 32'(bus.rf_waddr), 32'd31);
    chk("clr_end_wdata", bus.rf_wdata, 32'h0);
    chk("clr_end_done", 32'(bus.clr_done), 32'h1);
    chk("clr_end_ready", 32'(rdy()), 32'h1);
    if (bus.rf_we === 1'b1) clr_writes++;
    if (bus.clr_done === 1'b1) done_cnt++;
    chk("clr_write_count", 32'(clr_writes), 32'd31);
    chk("clr_done_count", 32'(done_cnt), 32'd1);
    tick();
    bus.req0_valid = 0;
    #1;
    chk("post_clr_we", 32'(bus.rf_we), 32'h1);
    chk("post_clr_waddr", 32'(bus.rf_waddr), 32'd7);
    chk("post_clr_wdata", bus.rf_wdata, 32'h77);
    chk("post_clr_done", 32'(bus.clr_done), 32'h0);
    tick();
    #1;
    chk("post_clr_idle_we", 32'(bus.rf_we), 32'h0);

    // Reset after the 10th clear write (pointer is 1 at this point)
    bus.clr_start = 1;
    tick();
    bus.clr_start = 0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("abort_pre_we", 32'(bus.rf_we), 32'h1);
    chk("abort_pre_waddr", 32'(bus.rf_waddr), 32'd10);
    rst = 1'b1;
    #1;
    chk("abort_we", 32'(bus.rf_we), 32'h0);
    chk("abort_waddr", 32'(bus.rf_waddr), 32'h0);
    chk("abort_busy", 32'(bus.clr_busy), 32'h0);
    chk("abort_done", 32'(bus.clr_done), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      chk("abort_idle_we", 32'(bus.rf_we), 32'h0);
      chk("abort_idle_done", 32'(bus.clr_done), 32'h0);
      chk("abort_idle_busy", 32'(bus.clr_busy), 32'h0);
      tick();
    end
    // Pointer back at 0: requester 0 wins over requester 1
    bus.req0_valid = 1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA;
    bus.req1_valid = 1; bus.req1_addr = 5'd4; bus.req1_data = 32'hB;
    #1;
    chk("abort_ptr_ready", 32'(rdy()), 32'h1);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    chk("abort_ptr_waddr", 32'(bus.rf_waddr), 32'd3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
